instr_fetch: RTL
================

# instr_fetch

Instruction fetch sequencer sitting directly downstream of the program counter. It gates the PC onto the address bus, runs a request/acknowledge read to instruction memory, and latches the opcode word (plus an optional immediate word). It pulses the PC increment once per word fetched and hands the completed instruction to the control unit over a valid/ready handshake.

## Interface
Parameters:
- DATA_WIDTH, 16, width of PC, address and instruction words
- IMM_BIT, 15, opcode bit that, when 1, marks a two-word instruction (immediate follows)

Ports:
- clk  input  1  system clock, all state changes on posedge
- notReset  input  1  asynchronous, active-low reset
- halt  input  1  when 1, no new fetch is started; the block parks in IDLE
- flush  input  1  abort any fetch in progress (control redirected PC)
- pc_bus  input  DATA_WIDTH  PC value (PC tri-state output)
- pc_read  output  1  enables PC onto pc_bus
- pc_inc  output  1  PC increment strobe, sampled by PC on posedge
- mem_req  output  1  memory read request
- mem_addr  output  DATA_WIDTH  memory address
- mem_ack  input  1  memory read done, mem_data valid this cycle
- mem_data  input  DATA_WIDTH  memory read data
- instr_valid  output  1  ir/imm hold a complete instruction
- instr_ready  input  1  control unit consumes the instruction
- ir  output  DATA_WIDTH  opcode word register
- imm  output  DATA_WIDTH  immediate word register (unchanged for one-word instructions)

## Operation
- States: IDLE, FETCH_OP, FETCH_IMM, VALID.
- IDLE: all strobes 0. halt=0 -> FETCH_OP next cycle.
- FETCH_OP / FETCH_IMM:
  - pc_read=1, mem_req=1, mem_addr=pc_bus (mem_addr=0 whenever mem_req=0).
  - Hold until mem_ack. On the ack cycle: pc_inc=1 (combinational: state and mem_ack and not flush); mem_data latched into ir (FETCH_OP) or imm (FETCH_IMM).
  - FETCH_OP with mem_data[IMM_BIT]=1 -> FETCH_IMM; otherwise -> VALID. FETCH_IMM -> VALID.
- VALID:
  - instr_valid=1; ir/imm stable, no memory activity.
  - On instr_ready=1: -> FETCH_OP if halt=0, else IDLE.
  - The control unit may write the PC in that same cycle (jump); the next fetch uses the new PC because FETCH_OP starts on the following cycle.
- flush has priority over mem_ack.
  - In FETCH_OP/FETCH_IMM: suppresses pc_inc and the latch, goes to IDLE.
  - In VALID: drops the instruction, goes to IDLE.
  - In IDLE: no effect.
- halt does not interrupt a fetch in progress; it is only checked at IDLE and at VALID handoff.
- pc_inc and pc_read are never asserted outside the fetch states, so the PC sees inc only with its own bus enable.

## Timing
- Reset (async, immediate): state=IDLE, ir=0, imm=0; all outputs 0 (pc_read, pc_inc, mem_req, mem_addr, instr_valid). A reset mid-transaction drops mem_req without waiting for mem_ack; a late ack is ignored.
- First fetch: FETCH_OP is entered on the first posedge after notReset rises with halt=0.
- Zero-wait memory (ack in the request cycle):
  - One-word instruction: FETCH_OP then VALID, instr_valid 1 cycle after fetch start.
  - Two-word instruction: 2 cycles.
- With instr_ready held 1, throughput is 1 instruction per 2 cycles (one-word) or 3 cycles (two-word).
- Each wait state without ack adds 1 cycle. mem_req, mem_addr and pc_read stay stable until ack or flush.
- PC advances exactly once per acknowledged word, on the ack-cycle edge. After a two-word fetch the PC has advanced by 2.
- Address arithmetic: none in this block; PC wrap (0xFFFF -> 0) is the PC's behaviour and is transparent here.

## Structure
- Shared header (include-guarded, used by control unit and bench): state encodings (2 bits: IDLE=0, FETCH_OP=1, FETCH_IMM=2, VALID=3) and the IMM_BIT default.
- No sub-module: one FSM, ir/imm registers and combinational strobe logic. Bench instantiates the PC alongside it with a behavioural memory model.

## Test plan
- Reset, PC=0x0000, mem[0]=0x1234, zero-wait -> ir=0x1234 and instr_valid=1 one cycle after FETCH_OP; PC=0x0001; imm=0.
- mem[1]=0x8001, mem[2]=0xBEEF -> ir=0x8001, imm=0xBEEF; exactly 2 pc_inc pulses; PC=0x0003.
- 3 wait states on the opcode fetch -> mem_req/mem_addr held 4 cycles; single pc_inc on the ack cycle.
- flush asserted in the ack cycle of FETCH_IMM -> no pc_inc, imm unchanged, IDLE, refetch from the new PC (e.g. 0x0040).
- instr_ready=0 for 5 cycles in VALID -> ir stable, no mem_req; PC written to 0x0100 in the ready cycle -> next mem_addr=0x0100.
- notReset pulsed low while mem_req=1 -> all outputs 0 immediately; later mem_ack ignored; fetch restarts after release.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch sequencer: FSM state
// encodings and the default position of the two-word opcode flag.
`ifndef INSTR_FETCH_PKG_SV
`define INSTR_FETCH_PKG_SV

package instr_fetch_pkg;

    // Encodings are fixed because the control unit decodes them directly.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FETCH_OP  = 2'd1,
        FETCH_IMM = 2'd2,
        VALID     = 2'd3
    } if_state_e;

    // Opcode bit that marks an instruction carrying a trailing immediate word.
    localparam int unsigned IMM_BIT_DEFAULT = 15;

endpackage

`endif

// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: gates the PC onto the address bus, runs a
// req/ack read for the opcode (and optional immediate) word, strobes the PC
// increment once per acknowledged word and offers the instruction to the
// control unit over a valid/ready handshake.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned IMM_BIT    = IMM_BIT_DEFAULT
) (
    input  logic                  clk,
    input  logic                  notReset,
    input  logic                  halt,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] pc_bus,
    output logic                  pc_read,
    output logic                  pc_inc,
    output logic                  mem_req,
    output logic [DATA_WIDTH-1:0] mem_addr,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] ir,
    output logic [DATA_WIDTH-1:0] imm
);

    if_state_e             state_q, state_d;
    logic [DATA_WIDTH-1:0] ir_q, ir_d;
    logic [DATA_WIDTH-1:0] imm_q, imm_d;
    logic                  fetching;
    logic                  word_done;

    // State register; reset drops any outstanding request immediately.
    always_ff @(posedge clk or negedge notReset) begin
        if (!notReset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush outranks both mem_ack and instr_ready.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (!halt) state_d = FETCH_OP;
            end
            FETCH_OP: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (mem_ack) begin
                    state_d = mem_data[IMM_BIT] ? FETCH_IMM : VALID;
                end
            end
            FETCH_IMM: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (mem_ack) begin
                    state_d = VALID;
                end
            end
            VALID: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (instr_ready) begin
                    state_d = halt ? IDLE : FETCH_OP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Strobes and word-latch enables, decoded from the current state.
    always_comb begin
        fetching    = (state_q == FETCH_OP) || (state_q == FETCH_IMM);
        word_done   = fetching && mem_ack && !flush;
        pc_read     = fetching;
        mem_req     = fetching;
        mem_addr    = fetching ? pc_bus : '0;
        pc_inc      = word_done;
        instr_valid = (state_q == VALID);
        ir_d        = ir_q;
        imm_d       = imm_q;
        if (word_done) begin
            if (state_q == FETCH_OP) begin
                ir_d = mem_data;
            end else begin
                imm_d = mem_data;
            end
        end
    end

    // Opcode and immediate registers; imm keeps its value for one-word opcodes.
    always_ff @(posedge clk or negedge notReset) begin
        if (!notReset) begin
            ir_q  <= '0;
            imm_q <= '0;
        end else begin
            ir_q  <= ir_d;
            imm_q <= imm_d;
        end
    end

    assign ir  = ir_q;
    assign imm = imm_q;

endmodule
